// File: rtl/opc_bus_pkg.sv
// Shared definitions for the OPC memory bus: arbiter state encodings (also used
// directly as the owner code) and the default bus widths.
package opc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam int OPC_AW = 12;
    localparam int OPC_DW = 8;

endpackage

// File: rtl/opc_rr_pick.sv
// Two-input round-robin picker: grants the sole requester, or the preferred
// master (prio) when both request.
module opc_rr_pick
    import opc_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;
    assign grant = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/opc_mem_arbiter.sv
// Round-robin two-master arbiter for the single OPC memory port, granting
// bursts of up to MAX_BURST beats with registered per-master acks.
module opc_mem_arbiter
    import opc_bus_pkg::*;
#(
    parameter int AW        = OPC_AW,
    parameter int DW        = OPC_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_rnw,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_rnw,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_ce,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rnw,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          ack0_q, ack1_q;
    logic          issue, own_is1, own_req, oth_req;
    logic          pick_gnt, pick_vld;
    arb_state_e    oth_state;

    opc_rr_pick u_pick (
        .req   ({m1_req, m0_req}),
        .prio  (prio_q),
        .grant (pick_gnt),
        .valid (pick_vld)
    );

    assign own_is1   = (state_q == ST_OWN1);
    assign own_req   = own_is1 ? m1_req : m0_req;
    assign oth_req   = own_is1 ? m0_req : m1_req;
    assign oth_state = own_is1 ? ST_OWN0 : ST_OWN1;
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = pick_gnt ? ST_OWN1 : ST_OWN0;
                    cnt_d   = '0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req) begin
                    // Voluntary release: no beat this cycle, hand the preference over.
                    state_d = oth_req ? oth_state : ST_IDLE;
                    prio_d  = ~own_is1;
                    cnt_d   = '0;
                end else begin
                    issue = 1'b1;
                    if (cnt_inc == CW'(MAX_BURST)) begin
                        // Burst limit: switch only if the other side is waiting.
                        cnt_d = '0;
                        if (oth_req) begin
                            state_d = oth_state;
                            prio_d  = ~own_is1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ce    = issue;
        mem_rnw   = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_rnw   = own_is1 ? m1_rnw   : m0_rnw;
            mem_addr  = own_is1 ? m1_addr  : m0_addr;
            mem_wdata = own_is1 ? m1_wdata : m0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            ack0_q  <= issue & ~own_is1;
            ack1_q  <= issue & own_is1;
        end
    end

    assign owner    = state_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_rdata = ack0_q ? mem_rdata : '0;
    assign m1_rdata = ack1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_opc_mem_arbiter.sv
// Directed bench for opc_mem_arbiter: a cycle table for contention and
// handover, plus hand-written reset, single-read and solo-burst sequences.
module tb_opc_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_rnw, m1_rnw;
    logic [11:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        mem_ce, mem_rnw;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [1:0]  owner;

    logic [7:0]  mem_arr [0:4095];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r0, r1;
        logic [1:0]  own;
        logic        ce;
        logic [11:0] addr;
        logic        a0, a1;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    opc_mem_arbiter #(.AW(12), .DW(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_rnw    (m0_rnw),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_rnw    (m1_rnw),
        .m1_wdata  (m1_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .mem_ce    (mem_ce),
        .mem_addr  (mem_addr),
        .mem_rnw   (mem_rnw),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_rnw) mem_rdata <= mem_arr[mem_addr];
            else         mem_arr[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic r1, input logic [1:0] own,
                                input logic ce, input logic [11:0] addr,
                                input logic a0, input logic a1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.own = own; v.ce = ce; v.addr = addr; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    task automatic reset_dut();
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 4096; i++) mem_arr[i] = 8'h00;
        mem_arr[12'h010] = 8'h11;
        mem_arr[12'h020] = 8'h22;
        mem_arr[12'h123] = 8'hA5;

        // Contention, burst-limit switches, release handover and prio rotation.
        tbl[0]  = mk(1, 1, 2'b00, 0, 12'h000, 0, 0);
        tbl[1]  = mk(1, 1, 2'b01, 1, 12'h010, 0, 0);
        tbl[2]  = mk(1, 1, 2'b01, 1, 12'h010, 1, 0);
        tbl[3]  = mk(1, 1, 2'b01, 1, 12'h010, 1, 0);
        tbl[4]  = mk(1, 1, 2'b01, 1, 12'h010, 1, 0);
        tbl[5]  = mk(1, 1, 2'b10, 1, 12'h020, 1, 0);
        tbl[6]  = mk(1, 1, 2'b10, 1, 12'h020, 0, 1);
        tbl[7]  = mk(1, 1, 2'b10, 1, 12'h020, 0, 1);
        tbl[8]  = mk(1, 1, 2'b10, 1, 12'h020, 0, 1);
        tbl[9]  = mk(1, 1, 2'b01, 1, 12'h010, 0, 1);
        tbl[10] = mk(1, 1, 2'b01, 1, 12'h010, 1, 0);
        tbl[11] = mk(0, 1, 2'b01, 0, 12'h000, 1, 0);
        tbl[12] = mk(1, 1, 2'b10, 1, 12'h020, 0, 0);
        tbl[13] = mk(0, 0, 2'b10, 0, 12'h000, 0, 1);
        tbl[14] = mk(1, 1, 2'b00, 0, 12'h000, 0, 0);
        tbl[15] = mk(0, 0, 2'b01, 0, 12'h000, 0, 0);
        tbl[16] = mk(1, 1, 2'b00, 0, 12'h000, 0, 0);
        tbl[17] = mk(0, 0, 2'b10, 0, 12'h000, 0, 0);

        m0_addr = 12'h010; m0_rnw = 1'b1; m0_wdata = 8'h00;
        m1_addr = 12'h020; m1_rnw = 1'b1; m1_wdata = 8'h00;

        // Reset held with both masters requesting.
        reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rst%0d.owner", c), owner, 2'b00);
            chk($sformatf("rst%0d.ce", c), mem_ce, 1'b0);
            chk($sformatf("rst%0d.acks", c), {m0_ack, m1_ack}, 2'b00);
        end
        chk("rst.rnw_idle", mem_rnw, 1'b1);
        chk("rst.addr_idle", mem_addr, 12'h000);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_rel.owner", owner, 2'b01);
        chk("rst_rel.ce", mem_ce, 1'b1);

        reset_dut();
        for (int i = 0; i < 18; i++) begin
            m0_req = tbl[i].r0;
            m1_req = tbl[i].r1;
            #1;
            chk($sformatf("vec%0d.owner", i), owner, tbl[i].own);
            chk($sformatf("vec%0d.ce", i), mem_ce, tbl[i].ce);
            chk($sformatf("vec%0d.addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("vec%0d.rnw", i), mem_rnw, 1'b1);
            chk($sformatf("vec%0d.ack0", i), m0_ack, tbl[i].a0);
            chk($sformatf("vec%0d.ack1", i), m1_ack, tbl[i].a1);
            chk($sformatf("vec%0d.rdata0", i), m0_rdata, tbl[i].a0 ? 8'h11 : 8'h00);
            chk($sformatf("vec%0d.rdata1", i), m1_rdata, tbl[i].a1 ? 8'h22 : 8'h00);
            @(negedge clk);
        end

        // Single read of 0x123 by m0.
        reset_dut();
        m0_addr = 12'h123; m0_rnw = 1'b1; m0_req = 1'b1;
        #1;
        chk("rd.t0_owner", owner, 2'b00);
        @(negedge clk); #1;
        chk("rd.t1_owner", owner, 2'b01);
        chk("rd.t1_ce", mem_ce, 1'b1);
        chk("rd.t1_addr", mem_addr, 12'h123);
        chk("rd.t1_rnw", mem_rnw, 1'b1);
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        chk("rd.t2_ack0", m0_ack, 1'b1);
        chk("rd.t2_rdata0", m0_rdata, 8'hA5);
        chk("rd.t2_ack1", m1_ack, 1'b0);
        chk("rd.t2_ce", mem_ce, 1'b0);
        @(negedge clk);

        // Solo burst: m1 writes 10 beats, never forced off the bus.
        m1_rnw = 1'b0; m1_addr = 12'h000; m1_wdata = 8'h50; m1_req = 1'b1;
        #1;
        chk("solo.t0_owner", owner, 2'b00);
        acks = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            m1_addr  = 12'(k - 1);
            m1_wdata = 8'(8'h50 + k - 1);
            #1;
            acks += int'(m1_ack);
            chk($sformatf("solo%0d.owner", k), owner, 2'b10);
            chk($sformatf("solo%0d.ce", k), mem_ce, 1'b1);
            chk($sformatf("solo%0d.rnw", k), mem_rnw, 1'b0);
            chk($sformatf("solo%0d.addr", k), mem_addr, 12'(k - 1));
            chk($sformatf("solo%0d.wdata", k), mem_wdata, 8'(8'h50 + k - 1));
        end
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        acks += int'(m1_ack);
        chk("solo.ack_count", acks, 10);
        chk("solo.ce_end", mem_ce, 1'b0);
        @(negedge clk); #1;
        chk("solo.idle_owner", owner, 2'b00);
        for (int k = 0; k < 10; k++)
            chk($sformatf("solo.mem%0d", k), mem_arr[k], 8'(8'h50 + k));

        // Reset during the beat of a read: its ack must be discarded.
        m0_addr = 12'h123; m0_rnw = 1'b1; m0_req = 1'b1;
        @(negedge clk); #1;
        chk("mrst.beat_ce", mem_ce, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m0_req = 1'b0;
        #1;
        chk("mrst.ack0", m0_ack, 1'b0);
        chk("mrst.rdata0", m0_rdata, 8'h00);
        chk("mrst.owner", owner, 2'b00);
        @(negedge clk); #1;
        chk("mrst.stay_idle", owner, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
